// File: rtl/writeback_stage_p_pkg.sv
// Shared status encodings, register-address constants and status helpers for the
// Y86-64 memory-to-writeback pipeline register.
package writeback_stage_p_pkg;

  localparam logic [3:0] STAT_RESET  = 4'h0;
  localparam logic [3:0] STAT_OK     = 4'h1;
  localparam logic [3:0] STAT_HLT    = 4'h2;
  localparam logic [3:0] STAT_ADR    = 4'h3;
  localparam logic [3:0] STAT_INS    = 4'h4;
  localparam logic [3:0] STAT_BUBBLE = 4'h5;
  localparam logic [3:0] STAT_STALL  = 4'h6;

  localparam logic [3:0] RNONE = 4'hF;

  // Terminating statuses stop the core; takes a widened status so any STAT_W <= 32 fits.
  function automatic logic stat_terminal(input logic [31:0] s);
    return (s == 32'(STAT_HLT)) || (s == 32'(STAT_ADR)) || (s == 32'(STAT_INS));
  endfunction

endpackage

// File: rtl/writeback_stage_p_we_gen.sv
// Combinational register-file write-enable generation for the writeback stage,
// including the dstE/dstM conflict rule and terminal-status detection.
module wb_we_gen
  import writeback_stage_p_pkg::*;
#(
  parameter int STAT_W = 4,
  parameter int REG_AW = 4
) (
  input  logic [STAT_W-1:0] stat_i,
  input  logic [REG_AW-1:0] dstE_i,
  input  logic [REG_AW-1:0] dstM_i,
  output logic              weE_o,
  output logic              weM_o,
  output logic              terminal_o
);

  logic stat_ok;
  logic e_live;
  logic m_live;

  assign stat_ok = (stat_i == STAT_W'(STAT_OK));
  assign e_live  = stat_ok && (dstE_i != {REG_AW{1'b1}});
  assign m_live  = stat_ok && (dstM_i != {REG_AW{1'b1}});

  // Same destination on both ports: the memory value wins (popq %rsp).
  assign weE_o      = e_live && !(m_live && (dstE_i == dstM_i));
  assign weM_o      = m_live;
  assign terminal_o = stat_terminal(32'(stat_i));

endmodule

// File: rtl/writeback_stage_p.sv
// Memory-to-writeback pipeline register with write-enable generation, bubble/stall
// handling, a sticky halt on terminating status and a retired-instruction counter.
module writeback_stage_p
  import writeback_stage_p_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int REG_AW  = 4,
  parameter int ICODE_W = 4,
  parameter int STAT_W  = 4,
  parameter int CNT_W   = 32
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               stall_i,
  input  logic               bubble_i,
  input  logic               valid_i,
  input  logic [ICODE_W-1:0] icode_i,
  input  logic [STAT_W-1:0]  stat_i,
  input  logic [DATA_W-1:0]  valE_i,
  input  logic [DATA_W-1:0]  valM_i,
  input  logic [REG_AW-1:0]  dstE_i,
  input  logic [REG_AW-1:0]  dstM_i,
  output logic [ICODE_W-1:0] icode_o,
  output logic [STAT_W-1:0]  stat_o,
  output logic [DATA_W-1:0]  valE_o,
  output logic [DATA_W-1:0]  valM_o,
  output logic [REG_AW-1:0]  dstE_o,
  output logic [REG_AW-1:0]  dstM_o,
  output logic               weE_o,
  output logic               weM_o,
  output logic               halted_o,
  output logic [CNT_W-1:0]   retired_o
);

  localparam logic [REG_AW-1:0] REG_NONE = {REG_AW{1'b1}};

  logic [ICODE_W-1:0] icode_q, icode_d;
  logic [STAT_W-1:0]  stat_q, stat_d;
  logic [DATA_W-1:0]  val_e_q, val_e_d;
  logic [DATA_W-1:0]  val_m_q, val_m_d;
  logic [REG_AW-1:0]  dst_e_q, dst_e_d;
  logic [REG_AW-1:0]  dst_m_q, dst_m_d;
  logic               we_e_q, we_e_d;
  logic               we_m_q, we_m_d;
  logic               halted_q, halted_d;
  logic [CNT_W-1:0]   retired_q, retired_d;

  logic we_e_cap;
  logic we_m_cap;
  logic terminal;

  wb_we_gen #(
    .STAT_W (STAT_W),
    .REG_AW (REG_AW)
  ) u_we_gen (
    .stat_i     (stat_i),
    .dstE_i     (dstE_i),
    .dstM_i     (dstM_i),
    .weE_o      (we_e_cap),
    .weM_o      (we_m_cap),
    .terminal_o (terminal)
  );

  // NOTE: every _d gets a default before any branch, so no path leaves it unassigned
  // and no latch is inferred; write enables default low so only a capture can write.
  always_comb begin
    icode_d   = icode_q;
    stat_d    = stat_q;
    val_e_d   = val_e_q;
    val_m_d   = val_m_q;
    dst_e_d   = dst_e_q;
    dst_m_d   = dst_m_q;
    we_e_d    = 1'b0;
    we_m_d    = 1'b0;
    halted_d  = halted_q;
    retired_d = retired_q;

    if (!halted_q) begin
      if (stall_i) begin
        stat_d = STAT_W'(STAT_STALL);
      end else if (bubble_i || !valid_i) begin
        icode_d = '0;
        stat_d  = STAT_W'(STAT_BUBBLE);
        val_e_d = '0;
        val_m_d = '0;
        dst_e_d = REG_NONE;
        dst_m_d = REG_NONE;
      end else begin
        icode_d  = icode_i;
        stat_d   = stat_i;
        val_e_d  = valE_i;
        val_m_d  = valM_i;
        dst_e_d  = dstE_i;
        dst_m_d  = dstM_i;
        we_e_d   = we_e_cap;
        we_m_d   = we_m_cap;
        halted_d = terminal;
        if (stat_i == STAT_W'(STAT_OK)) retired_d = retired_q + CNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      icode_q   <= '0;
      stat_q    <= STAT_W'(STAT_RESET);
      val_e_q   <= '0;
      val_m_q   <= '0;
      dst_e_q   <= REG_NONE;
      dst_m_q   <= REG_NONE;
      we_e_q    <= 1'b0;
      we_m_q    <= 1'b0;
      halted_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      icode_q   <= icode_d;
      stat_q    <= stat_d;
      val_e_q   <= val_e_d;
      val_m_q   <= val_m_d;
      dst_e_q   <= dst_e_d;
      dst_m_q   <= dst_m_d;
      we_e_q    <= we_e_d;
      we_m_q    <= we_m_d;
      halted_q  <= halted_d;
      retired_q <= retired_d;
    end
  end

  assign icode_o   = icode_q;
  assign stat_o    = stat_q;
  assign valE_o    = val_e_q;
  assign valM_o    = val_m_q;
  assign dstE_o    = dst_e_q;
  assign dstM_o    = dst_m_q;
  assign weE_o     = we_e_q;
  assign weM_o     = we_m_q;
  assign halted_o  = halted_q;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_writeback_stage_p.sv
// Directed self-checking bench for writeback_stage_p; a second narrow-counter
// instance shares the stimulus to exercise counter wrap-around.
module tb_writeback_stage_p;
  import writeback_stage_p_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        bubble;
  logic        valid;
  logic [3:0]  icode;
  logic [3:0]  stat;
  logic [63:0] val_e;
  logic [63:0] val_m;
  logic [3:0]  dst_e;
  logic [3:0]  dst_m;

  logic [3:0]  icode_o, stat_o, dst_e_o, dst_m_o;
  logic [63:0] val_e_o, val_m_o;
  logic        we_e_o, we_m_o, halted_o;
  logic [31:0] retired_o;

  logic [3:0]  w_icode_o, w_stat_o, w_dst_e_o, w_dst_m_o;
  logic [63:0] w_val_e_o, w_val_m_o;
  logic        w_we_e_o, w_we_m_o, w_halted_o;
  logic [2:0]  w_retired_o;

  int n_pass;
  int n_total;

  writeback_stage_p dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .stall_i   (stall),
    .bubble_i  (bubble),
    .valid_i   (valid),
    .icode_i   (icode),
    .stat_i    (stat),
    .valE_i    (val_e),
    .valM_i    (val_m),
    .dstE_i    (dst_e),
    .dstM_i    (dst_m),
    .icode_o   (icode_o),
    .stat_o    (stat_o),
    .valE_o    (val_e_o),
    .valM_o    (val_m_o),
    .dstE_o    (dst_e_o),
    .dstM_o    (dst_m_o),
    .weE_o     (we_e_o),
    .weM_o     (we_m_o),
    .halted_o  (halted_o),
    .retired_o (retired_o)
  );

  writeback_stage_p #(.CNT_W(3)) u_wrap (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .stall_i   (stall),
    .bubble_i  (bubble),
    .valid_i   (valid),
    .icode_i   (icode),
    .stat_i    (stat),
    .valE_i    (val_e),
    .valM_i    (val_m),
    .dstE_i    (dst_e),
    .dstM_i    (dst_m),
    .icode_o   (w_icode_o),
    .stat_o    (w_stat_o),
    .valE_o    (w_val_e_o),
    .valM_o    (w_val_m_o),
    .dstE_o    (w_dst_e_o),
    .dstM_o    (w_dst_m_o),
    .weE_o     (w_we_e_o),
    .weM_o     (w_we_m_o),
    .halted_o  (w_halted_o),
    .retired_o (w_retired_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Apply inputs on the falling edge, well away from the capturing edge.
  task automatic drive(input logic v, input logic b, input logic s, input logic [3:0] ic,
                       input logic [3:0] st, input logic [63:0] e, input logic [63:0] m,
                       input logic [3:0] de, input logic [3:0] dm);
    @(negedge clk);
    valid  = v;
    bubble = b;
    stall  = s;
    icode  = ic;
    stat   = st;
    val_e  = e;
    val_m  = m;
    dst_e  = de;
    dst_m  = dm;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst_n   = 1'b0;
    {stall, bubble, valid} = 3'b000;
    icode = '0; stat = '0; val_e = '0; val_m = '0; dst_e = '0; dst_m = '0;

    #12;
    check("rst_stat",    64'(stat_o), 64'(STAT_RESET));
    check("rst_dstE",    64'(dst_e_o), 64'hF);
    check("rst_dstM",    64'(dst_m_o), 64'hF);
    check("rst_weE",     64'(we_e_o), 64'd0);
    check("rst_weM",     64'(we_m_o), 64'd0);
    check("rst_halted",  64'(halted_o), 64'd0);
    check("rst_retired", 64'(retired_o), 64'd0);
    check("rst_valE",    64'(val_e_o), 64'd0);

    @(negedge clk);
    rst_n = 1'b1;

    // Plain OK capture, E write only.
    drive(1, 0, 0, 4'h6, STAT_OK, 64'h5, 64'h0, 4'h3, RNONE);
    tick();
    check("cap_valE",    val_e_o, 64'h5);
    check("cap_icode",   64'(icode_o), 64'h6);
    check("cap_stat",    64'(stat_o), 64'(STAT_OK));
    check("cap_dstE",    64'(dst_e_o), 64'h3);
    check("cap_weE",     64'(we_e_o), 64'd1);
    check("cap_weM",     64'(we_m_o), 64'd0);
    check("cap_retired", 64'(retired_o), 64'd1);

    // Bubble must produce RNONE destinations, not register 0.
    drive(1, 1, 0, 4'h6, STAT_OK, 64'h9, 64'h9, 4'h2, 4'h2);
    tick();
    check("bub_dstE",    64'(dst_e_o), 64'hF);
    check("bub_dstM",    64'(dst_m_o), 64'hF);
    check("bub_stat",    64'(stat_o), 64'(STAT_BUBBLE));
    check("bub_valE",    val_e_o, 64'h0);
    check("bub_weE",     64'(we_e_o), 64'd0);
    check("bub_retired", 64'(retired_o), 64'd1);

    // Stall with bubble: stall wins, payload held, no repeated write.
    drive(1, 0, 0, 4'h2, STAT_OK, 64'h77, 64'h0, 4'h5, RNONE);
    tick();
    check("pre_stall_weE", 64'(we_e_o), 64'd1);
    drive(1, 1, 1, 4'h9, STAT_OK, 64'h55, 64'h66, 4'h1, 4'h1);
    tick();
    check("stall_stat",    64'(stat_o), 64'(STAT_STALL));
    check("stall_valE",    val_e_o, 64'h77);
    check("stall_icode",   64'(icode_o), 64'h2);
    check("stall_dstE",    64'(dst_e_o), 64'h5);
    check("stall_weE",     64'(we_e_o), 64'd0);
    check("stall_retired", 64'(retired_o), 64'd2);

    // valid_i low acts as a bubble.
    drive(0, 0, 0, 4'h6, STAT_OK, 64'h1, 64'h1, 4'h1, 4'h1);
    tick();
    check("inv_stat", 64'(stat_o), 64'(STAT_BUBBLE));
    check("inv_dstM", 64'(dst_m_o), 64'hF);
    check("inv_weM",  64'(we_m_o), 64'd0);

    // popq %rsp: both ports target %rsp, M wins.
    drive(1, 0, 0, 4'hB, STAT_OK, 64'h108, 64'hABC, 4'h4, 4'h4);
    tick();
    check("popq_weE",     64'(we_e_o), 64'd0);
    check("popq_weM",     64'(we_m_o), 64'd1);
    check("popq_valM",    val_m_o, 64'hABC);
    check("popq_valE",    val_e_o, 64'h108);
    check("popq_retired", 64'(retired_o), 64'd3);

    // Distinct destinations: both ports write.
    drive(1, 0, 0, 4'hB, STAT_OK, 64'h10, 64'h20, 4'h4, 4'h5);
    tick();
    check("both_weE", 64'(we_e_o), 64'd1);
    check("both_weM", 64'(we_m_o), 64'd1);
    check("wrap_mid", 64'(w_retired_o), 64'd4);

    // Four more retirements: 32-bit counter reaches 8, 3-bit counter wraps 7 -> 0.
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 4'h6, STAT_OK, 64'(i), 64'h0, 4'h6, RNONE);
      tick();
    end
    check("cnt_eight", 64'(retired_o), 64'd8);
    check("cnt_wrap",  64'(w_retired_o), 64'd0);

    // Address exception: halt on the same edge, no register write.
    drive(1, 0, 0, 4'h5, STAT_ADR, 64'h20, 64'h0, 4'h1, RNONE);
    tick();
    check("adr_halted",  64'(halted_o), 64'd1);
    check("adr_weE",     64'(we_e_o), 64'd0);
    check("adr_stat",    64'(stat_o), 64'(STAT_ADR));
    check("adr_retired", 64'(retired_o), 64'd8);

    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 4'h6, STAT_OK, 64'h99, 64'h0, 4'h7, RNONE);
      tick();
      check("hold_valE",    val_e_o, 64'h20);
      check("hold_stat",    64'(stat_o), 64'(STAT_ADR));
      check("hold_weE",     64'(we_e_o), 64'd0);
      check("hold_retired", 64'(retired_o), 64'd8);
      check("hold_halted",  64'(halted_o), 64'd1);
    end

    // Asynchronous reset between edges while halted.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_stat",    64'(stat_o), 64'(STAT_RESET));
    check("arst_valE",    val_e_o, 64'h0);
    check("arst_dstE",    64'(dst_e_o), 64'hF);
    check("arst_halted",  64'(halted_o), 64'd0);
    check("arst_retired", 64'(retired_o), 64'd0);
    check("arst_icode",   64'(icode_o), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
